// File: rtl/trig_pkg.sv
// rtl/trig_pkg.sv - shared types and defaults for the trigger scheduler
// Contents: FSM state encoding, channel index constants, default timing
// parameters and a channel-to-one-hot helper.
package trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int TRIG_CYC_DEF = 500;      // 10 us at 50 MHz
  localparam int UNIT_CYC_DEF = 2500000;  // 50 ms at 50 MHz
  localparam int CNT_W_DEF    = 26;

  function automatic logic [1:0] ch_onehot(input logic ch);
    return (ch == CH1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/trig_sched_if.sv
// rtl/trig_sched_if.sv - request/response bundle of the trigger scheduler
// master: drives req, code0, code1, abort; observes grant, trig, window, done, busy
// slave : the scheduler side of the same signals
interface trig_sched_if;
  logic [1:0] req;
  logic [3:0] code0;
  logic [3:0] code1;
  logic       abort;
  logic [1:0] grant;
  logic [1:0] trig;
  logic [1:0] window;
  logic [1:0] done;
  logic       busy;

  modport master (
    output req, code0, code1, abort,
    input  grant, trig, window, done, busy
  );

  modport slave (
    input  req, code0, code1, abort,
    output grant, trig, window, done, busy
  );
endinterface

// File: rtl/dwell_cnt.sv
// rtl/dwell_cnt.sv - loadable down-counter timing each scheduler state
// Ports: clk, rst (async active-low), load_i/val_i (load value), en_i
// (decrement), zero_o (count reads zero). Never wraps below zero.
module dwell_cnt #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/trig_sched.sv
// rtl/trig_sched.sv - two-channel trigger/listen-window scheduler
// Ports: clk, rst (async active-low), bus (trig_sched_if.slave):
// req/code0/code1/abort in; grant/trig/window/done/busy out (all registered).
module trig_sched
  import trig_pkg::*;
#(
  parameter int TRIG_CYC = TRIG_CYC_DEF,
  parameter int UNIT_CYC = UNIT_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  trig_sched_if.slave  bus
);

  // The longest window (16 units) and the trigger pulse must fit the counter.
  if ((longint'(UNIT_CYC) * 16 > (longint'(1) << CNT_W)) ||
      (longint'(TRIG_CYC) > (longint'(1) << CNT_W)) ||
      (TRIG_CYC < 1) || (UNIT_CYC < 1)) begin : g_width_chk
    $error("trig_sched: CNT_W too small for TRIG_CYC/UNIT_CYC");
  end

  localparam logic [CNT_W-1:0] TRIG_LD = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] UNIT_V  = CNT_W'(UNIT_CYC);

  state_e     state_q;
  logic [1:0] grant_q, trig_q, window_q, done_q;
  logic       busy_q;
  logic       last_q;   // last-served channel
  logic       chan_q;   // channel owning the current operation
  logic [3:0] code_q;

  logic             pick_d;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] win_len;

  // Tie goes to the channel that was not served last.
  always_comb begin
    pick_d = CH0;
    case (bus.req)
      2'b01:   pick_d = CH0;
      2'b10:   pick_d = CH1;
      default: pick_d = ~last_q;
    endcase
  end

  assign win_len = CNT_W'({1'b0, code_q} + 5'd1) * UNIT_V;

  // Counter holds (length-1) on state entry; the state exits when it reads zero.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: if (|bus.req) begin
        cnt_load = 1'b1;
        cnt_val  = TRIG_LD;
      end
      ST_TRIG: if (bus.abort) begin
        cnt_load = 1'b1;
      end else if (cnt_zero) begin
        cnt_load = 1'b1;
        cnt_val  = win_len - CNT_W'(1);
      end else begin
        cnt_en = 1'b1;
      end
      ST_WAIT: if (bus.abort) cnt_load = 1'b1;
               else           cnt_en   = 1'b1;
      default: ;
    endcase
  end

  dwell_cnt #(.CNT_W(CNT_W)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .val_i  (cnt_val),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      trig_q   <= '0;
      window_q <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      last_q   <= CH1;
      chan_q   <= CH0;
      code_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (|bus.req) begin
          state_q <= ST_TRIG;
          chan_q  <= pick_d;
          grant_q <= ch_onehot(pick_d);
          trig_q  <= ch_onehot(pick_d);
          code_q  <= (pick_d == CH1) ? bus.code1 : bus.code0;
          busy_q  <= 1'b1;
        end
        ST_TRIG, ST_WAIT: if (bus.abort) begin
          // Abort beats a same-cycle completion: no done pulse.
          state_q  <= ST_IDLE;
          grant_q  <= '0;
          trig_q   <= '0;
          window_q <= '0;
          busy_q   <= 1'b0;
          last_q   <= chan_q;
        end else if (cnt_zero) begin
          if (state_q == ST_TRIG) begin
            state_q  <= ST_WAIT;
            trig_q   <= '0;
            window_q <= grant_q;
          end else begin
            state_q  <= ST_DONE;
            window_q <= '0;
            done_q   <= grant_q;
            last_q   <= chan_q;
          end
        end
        default: begin
          // DONE (with or without abort) always returns to IDLE.
          state_q <= ST_IDLE;
          grant_q <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          last_q  <= chan_q;
        end
      endcase
    end
  end

  assign bus.grant  = grant_q;
  assign bus.trig   = trig_q;
  assign bus.window = window_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_trig_sched.sv
// tb/tb_trig_sched.sv - self-checking randomized bench for trig_sched
module tb_trig_sched;

  localparam int T_CYC = 5;
  localparam int U_CYC = 10;
  localparam int C_W   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   inv_bad  = 0;
  int   last_m   = 1;

  trig_sched_if bus ();

  trig_sched #(.TRIG_CYC(T_CYC), .UNIT_CYC(U_CYC), .CNT_W(C_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Structural rules sampled every cycle outside reset.
  always @(negedge clk) begin
    if (rst) begin
      if ($countones(bus.grant) > 1 || $countones(bus.trig) > 1 ||
          $countones(bus.window) > 1 || $countones(bus.done) > 1) inv_bad++;
      if ((|bus.trig) && (|bus.window)) inv_bad++;
      if ((|bus.done) && (bus.done != bus.grant)) inv_bad++;
      if (bus.busy != (|bus.grant)) inv_bad++;
      if ((|(bus.trig | bus.window | bus.done)) && !bus.busy) inv_bad++;
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge of the next idle cycle.
  // k: 1-based busy cycle during which abort is held high (0 = no abort).
  task automatic run_op(input logic [1:0] r, input logic [3:0] c0, input logic [3:0] c1, input int k);
    int ch, w, full, eff, cyc, busy_n, trig_n, win_n, done_n, gbad, exp_trig, exp_win;
    logic [1:0] exp_g;
    logic [3:0] lc;
    ch    = (r == 2'b01) ? 0 : (r == 2'b10) ? 1 : (last_m == 0 ? 1 : 0);
    exp_g = (ch == 1) ? 2'b10 : 2'b01;
    lc    = (ch == 1) ? c1 : c0;
    w     = (int'(lc) + 1) * U_CYC;
    full  = T_CYC + w + 1;
    eff   = (k >= 1 && k <= full) ? k : full;
    bus.req = r; bus.code0 = c0; bus.code1 = c1; bus.abort = 1'b0;
    cyc = 0; busy_n = 0; trig_n = 0; win_n = 0; done_n = 0; gbad = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (!bus.busy) break;
      if (cyc > 400) begin
        check("op_timeout", 32'(cyc), 32'(full));
        break;
      end
      busy_n++;
      if (cyc == 1) check("grant_first", 32'(bus.grant), 32'(exp_g));
      if (bus.grant != exp_g) gbad++;
      if (bus.trig == exp_g) trig_n++; else if (bus.trig != 2'b00) gbad++;
      if (bus.window == exp_g) win_n++; else if (bus.window != 2'b00) gbad++;
      if (bus.done == exp_g) done_n++; else if (bus.done != 2'b00) gbad++;
      // Inputs after grant must not matter.
      bus.req   = 2'($urandom);
      bus.code0 = 4'($urandom);
      bus.code1 = 4'($urandom);
      bus.abort = (cyc == k);
    end
    bus.req = 2'b00; bus.abort = 1'b0;
    exp_trig = (eff < T_CYC) ? eff : T_CYC;
    exp_win  = (eff <= T_CYC) ? 0 : ((eff - T_CYC > w) ? w : eff - T_CYC);
    check("busy_len", 32'(busy_n), 32'(eff));
    check("trig_len", 32'(trig_n), 32'(exp_trig));
    check("win_len", 32'(win_n), 32'(exp_win));
    check("done_cnt", 32'(done_n), (eff == full) ? 32'd1 : 32'd0);
    check("grant_hold", 32'(gbad), 32'd0);
    check("idle_outs", 32'({bus.grant, bus.trig, bus.window, bus.done}), 32'd0);
    last_m = ch;
  endtask

  initial begin
    int k;
    bus.req = 2'b00; bus.code0 = 4'd0; bus.code1 = 4'd0; bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outs", 32'({bus.grant, bus.trig, bus.window, bus.done, bus.busy}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_rst", 32'(bus.busy), 32'd0);

    // Directed: single ch0, tie sequence, long ch1 window, abort in WAIT cycle 3.
    run_op(2'b01, 4'd0, 4'd0, 0);
    run_op(2'b11, 4'd1, 4'd2, 0);
    run_op(2'b11, 4'd1, 4'd2, 0);
    run_op(2'b11, 4'd1, 4'd2, 0);
    run_op(2'b10, 4'd0, 4'd15, 0);
    run_op(2'b11, 4'd4, 4'd4, T_CYC + 3);
    run_op(2'b11, 4'd2, 4'd2, 0);
    run_op(2'b01, 4'd0, 4'd0, T_CYC + U_CYC);   // abort on completion cycle
    run_op(2'b10, 4'd0, 4'd0, T_CYC + U_CYC + 1); // abort in DONE
    run_op(2'b01, 4'd0, 4'd0, 2);                 // abort in TRIG

    // No request plus abort while idle: nothing starts.
    begin
      int started = 0;
      bus.abort = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (bus.busy) started++;
      end
      bus.abort = 1'b0;
      check("idle_abort", 32'(started), 32'd0);
    end

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 170)) : 0;
      run_op(r, 4'($urandom), 4'($urandom), k);
    end

    // Asynchronous reset in the middle of TRIG.
    bus.req = 2'b10; bus.code1 = 4'd3;
    @(negedge clk);
    bus.req = 2'b00;
    @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #1 rst = 1'b0;
    #1 check("async_rst_outs", 32'({bus.grant, bus.trig, bus.window, bus.done, bus.busy}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    last_m = 1;
    run_op(2'b11, 4'd2, 4'd5, 0);
    run_op(2'b11, 4'd0, 4'd1, 0);

    check("invariants", 32'(inv_bad), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
